// File: rtl/serializer_defs_pkg.sv
// -----------------------------------------------------------------------------
// serializer_defs
// Definitions shared by the serializer family (this serializer and a future
// deserializer): FSM state encodings and the counter sizing helper.
// No ports; import with "import serializer_defs::*;".
// -----------------------------------------------------------------------------
package serializer_defs;

    // Transfer FSM states; the encodings are fixed so that other blocks and
    // debug tooling agree on them.
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } ser_state_e;

    // Width of a counter able to index bits 0..width-1, never below one bit.
    function automatic int cnt_width(input int width);
        int w;
        w = $clog2(width);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/bit_counter.sv
// -----------------------------------------------------------------------------
// bit_counter
// Small bit-position counter shared by serializer/deserializer blocks.
// Ports:
//   clk    in   clock, rising edge
//   clr_n  in   asynchronous active-low reset, clears count
//   clear  in   synchronous clear (wins over inc)
//   inc    in   increment by one
//   count  out  [CW-1:0] current bit index
// -----------------------------------------------------------------------------
module bit_counter #(
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic          clear,
    input  logic          inc,
    output logic [CW-1:0] count
);

    logic [CW-1:0] count_r;

    // Bit index register: clear has priority so a new word always starts at 0.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            count_r <= {CW{1'b0}};
        end else if (clear) begin
            count_r <= {CW{1'b0}};
        end else if (inc) begin
            count_r <= count_r + CW'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/register_serializer.sv
// -----------------------------------------------------------------------------
// register_serializer
// Captures a WIDTH-bit word on load (when idle) and shifts it out one bit per
// enabled cycle, LSB or MSB first, followed by a one-cycle done pulse.
// Ports:
//   clk         in   clock, rising edge
//   clr_n       in   asynchronous active-low reset
//   load        in   capture d (honoured only when idle)
//   d           in   [WIDTH-1:0] parallel word
//   en          in   shift enable, low stalls the transfer
//   sout        out  current serial bit (straight from the shift register)
//   sout_valid  out  sout is transferred this cycle (SHIFT and en)
//   busy        out  word in flight (SHIFT or DONE)
//   done        out  one-cycle completion pulse
// -----------------------------------------------------------------------------
module register_serializer
    import serializer_defs::*;
#(
    parameter int WIDTH     = 32,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             en,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    ser_state_e       state_r;
    ser_state_e       state_s;
    logic [WIDTH-1:0] shreg_r;
    logic [CW-1:0]    count_s;
    logic             accept_s;
    logic             shift_s;
    logic             last_s;
    logic             inc_s;
    logic             busy_r;
    logic             done_r;

    // The counter stops at WIDTH-1 on the final bit instead of wrapping; it is
    // cleared again by the next accepted load.
    bit_counter #(
        .CW (CW)
    ) u_bit_counter (
        .clk   (clk),
        .clr_n (clr_n),
        .clear (accept_s),
        .inc   (inc_s),
        .count (count_s)
    );

    // State register.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode and per-cycle control strobes.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        shift_s  = 1'b0;
        last_s   = (count_s == LAST);
        case (state_r)
            S_IDLE: begin
                if (load) begin
                    accept_s = 1'b1;
                    state_s  = S_SHIFT;
                end else begin
                    state_s  = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (en) begin
                    shift_s = 1'b1;
                    if (last_s) begin
                        state_s = S_DONE;
                    end else begin
                        state_s = S_SHIFT;
                    end
                end else begin
                    state_s = S_SHIFT;
                end
            end
            S_DONE: begin
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    assign inc_s = shift_s & ~last_s;

    // Shift register: zero fill means it is empty again once the last bit has
    // left, which keeps sout at 0 in DONE and IDLE without extra gating.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            shreg_r <= {WIDTH{1'b0}};
        end else if (accept_s) begin
            shreg_r <= d;
        end else if (shift_s) begin
            if (LSB_FIRST) begin
                shreg_r <= {1'b0, shreg_r[WIDTH-1:1]};
            end else begin
                shreg_r <= {shreg_r[WIDTH-2:0], 1'b0};
            end
        end else begin
            shreg_r <= shreg_r;
        end
    end

    // Status flags registered from the next state so they line up with state_r.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_s != S_IDLE);
            done_r <= (state_s == S_DONE);
        end
    end

    assign sout       = LSB_FIRST ? shreg_r[0] : shreg_r[WIDTH-1];
    assign sout_valid = (state_r == S_SHIFT) & en;
    assign busy       = busy_r;
    assign done       = done_r;

endmodule

// File: tb/tb_register_serializer.sv
// -----------------------------------------------------------------------------
// tb_register_serializer
// Drives one LSB-first and one MSB-first serializer with identical stimulus.
// A transfer-level reference model pushes the expected bit stream of every
// accepted word into a per-instance queue; a negedge monitor pops and compares
// whenever sout_valid is high and checks the status outputs every cycle.
// -----------------------------------------------------------------------------
module tb_register_serializer;

    localparam int W = 32;

    logic         clk;
    logic         clr_n;
    logic         load;
    logic [W-1:0] d;
    logic         en;

    logic sout_l, sv_l, busy_l, done_l;
    logic sout_m, sv_m, busy_m, done_m;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: bits still to send, and done-cycle flag.
    int m_rem  = 0;
    bit m_done = 1'b0;
    bit q_l[$];
    bit q_m[$];

    register_serializer #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_l (
        .clk(clk), .clr_n(clr_n), .load(load), .d(d), .en(en),
        .sout(sout_l), .sout_valid(sv_l), .busy(busy_l), .done(done_l)
    );

    register_serializer #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_m (
        .clk(clk), .clr_n(clr_n), .load(load), .d(d), .en(en),
        .sout(sout_m), .sout_valid(sv_m), .busy(busy_m), .done(done_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a word is accepted only when nothing is in flight; each
    // enabled cycle consumes one bit; the cycle after the last bit is done.
    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            m_rem  <= 0;
            m_done <= 1'b0;
            q_l.delete();
            q_m.delete();
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (m_rem > 0) begin
            if (en) begin
                m_rem <= m_rem - 1;
                if (m_rem == 1) m_done <= 1'b1;
            end
        end else if (load) begin
            m_rem <= W;
            for (int i = 0; i < W; i++) begin
                q_l.push_back(d[i]);
                q_m.push_back(d[W-1-i]);
            end
        end
    end

    // Monitor: status every cycle, serial bits against the scoreboard queues.
    always @(negedge clk) begin
        bit exp_busy;
        bit exp_sv;
        bit exp_bit;
        exp_busy = (m_rem > 0) || m_done;
        exp_sv   = (m_rem > 0) && (en === 1'b1);
        check("busy_lsb", busy_l, exp_busy);
        check("busy_msb", busy_m, exp_busy);
        check("done_lsb", done_l, m_done);
        check("done_msb", done_m, m_done);
        check("valid_lsb", sv_l, exp_sv);
        check("valid_msb", sv_m, exp_sv);
        if (sv_l === 1'b1) begin
            if (q_l.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_lsb: sout_valid with no expected bit (t=%0t)", $time);
            end else begin
                exp_bit = q_l.pop_front();
                check("sout_lsb", sout_l, exp_bit);
            end
        end
        if (sv_m === 1'b1) begin
            if (q_m.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_msb: sout_valid with no expected bit (t=%0t)", $time);
            end else begin
                exp_bit = q_m.pop_front();
                check("sout_msb", sout_m, exp_bit);
            end
        end
        if (m_rem == 0) begin
            check("sout_idle_lsb", sout_l, 1'b0);
            check("sout_idle_msb", sout_m, 1'b0);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sout_l"}, sout_l, 1'b0);
        check({tag, "_sv_l"},   sv_l,   1'b0);
        check({tag, "_busy_l"}, busy_l, 1'b0);
        check({tag, "_done_l"}, done_l, 1'b0);
        check({tag, "_sout_m"}, sout_m, 1'b0);
        check({tag, "_sv_m"},   sv_m,   1'b0);
        check({tag, "_busy_m"}, busy_m, 1'b0);
        check({tag, "_done_m"}, done_m, 1'b0);
    endtask

    // Send one word. en_mode: 0 = always 1, 1 = alternating starting at 1,
    // 2 = random. inj_at: cycle of a (to be ignored) second load, 0 = none,
    // -1 = random loads. rst_at: cycle of an asynchronous reset, 0 = none.
    // exp_done: expected done cycle counted from the load edge, -1 = any.
    task automatic run_word(input logic [W-1:0] data, input int en_mode,
                            input int inj_at, input int rst_at, input int exp_done);
        bit seen;
        seen = 1'b0;
        load = 1'b1;
        d    = data;
        cyc();
        load = 1'b0;
        for (int n = 1; n <= 400; n++) begin
            case (en_mode)
                0:       en = 1'b1;
                1:       en = (n % 2 == 1);
                default: en = ($urandom_range(0, 3) != 0);
            endcase
            if (inj_at == -1) begin
                load = ($urandom_range(0, 7) == 0);
                d    = $urandom;
            end else if (n == inj_at) begin
                load = 1'b1;
                d    = {W{1'b1}};
            end else begin
                load = 1'b0;
            end
            if (rst_at != 0 && n == rst_at) begin
                #1 clr_n = 1'b0;
                #1 check_all_zero("async_rst");
                cyc();
                cyc();
                load  = 1'b0;
                clr_n = 1'b1;
                for (int k = 0; k < 40; k++) begin
                    en = 1'b1;
                    check("no_done_after_abort", done_l | done_m, 1'b0);
                    cyc();
                end
                return;
            end
            if (done_l === 1'b1) begin
                if (exp_done >= 0) check("done_cycle", n, exp_done);
                check("done_msb_same_cycle", done_m, 1'b1);
                check("stream_lsb_complete", q_l.size(), 0);
                check("stream_msb_complete", q_m.size(), 0);
                seen = 1'b1;
                load = 1'b0;
                cyc();
                check("busy_falls_lsb", busy_l, 1'b0);
                check("busy_falls_msb", busy_m, 1'b0);
                break;
            end
            cyc();
        end
        if (!seen) begin
            n_checks++;
            n_errors++;
            $display("FAIL done_timeout: no done within 400 cycles of load %0h", data);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clr_n = 1'b0;
        load  = 1'b1;
        d     = {W{1'b1}};
        en    = 1'b1;
        #1 check_all_zero("reset_t0");
        for (int i = 0; i < 3; i++) begin
            cyc();
            check_all_zero("reset_hold");
        end
        load  = 1'b0;
        clr_n = 1'b1;
        cyc();
        cyc();
        check_all_zero("idle_after_release");

        run_word(32'hA5A50001, 0, 0, 0, 33);
        run_word(32'hA5A50001, 1, 0, 0, 64);
        run_word(32'h12345678, 0, 6, 0, 33);
        run_word(32'hCAFEF00D, 0, 0, 11, -1);
        run_word(32'h0000000F, 0, 0, 0, 33);
        run_word(32'h80000000, 0, 0, 0, 33);

        for (int it = 0; it < 20; it++) begin
            run_word($urandom, 2, (it % 2 == 0) ? -1 : 0, 0, -1);
        end
        load = 1'b0;
        for (int k = 0; k < 4; k++) cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/register_serializer.md
REGISTER_SERIALIZER -- requirements
Module: register_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 32: bit width of the captured word (2..64).
REQ-002 SHALL have parameter LSB_FIRST, default 1: 1 = shift out bit 0 first, 0 = bit WIDTH-1 first.
REQ-003 SHALL have port clk  input  1  the only clock; all state changes on its rising edge.
REQ-004 SHALL have port clr_n  input  1  reset: asynchronous, active-low.
REQ-005 SHALL have port load  input  1  request to capture d.
REQ-006 SHALL have port d  input  WIDTH  parallel word to transmit.
REQ-007 SHALL have port en  input  1  shift enable; low stalls the transfer.
REQ-008 SHALL have port sout  output  1  current serial bit.
REQ-009 SHALL have port sout_valid  output  1  sout transfers this cycle.
REQ-010 SHALL have port busy  output  1  word in flight; load not accepted.
REQ-011 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-012 SHALL implement states IDLE, SHIFT and DONE.
REQ-013 In IDLE, load=1 at a rising edge SHALL capture d into the shift register, clear the bit counter and enter SHIFT.
REQ-014 load SHALL be ignored in SHIFT and DONE: no recapture, no effect on the word in flight.
REQ-015 In SHIFT, sout SHALL equal shreg[0] if LSB_FIRST=1, else shreg[WIDTH-1], driven directly from the register.
REQ-016 sout_valid SHALL be 1 exactly when state=SHIFT and en=1; it is combinational on en.
REQ-017 At each edge in SHIFT with en=1, the shift register SHALL shift one position toward the output end, zero-filled, and the counter SHALL increment.
REQ-018 With en=0 in SHIFT, the shift register, counter and state SHALL hold.
REQ-019 The edge transferring bit index WIDTH-1 (counter=WIDTH-1, en=1) SHALL move the state to DONE.
REQ-020 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-021 busy SHALL be 1 in SHIFT and DONE, and 0 in IDLE.
REQ-022 In IDLE and DONE, sout SHALL be 0.
REQ-023 Latency: with en held at 1, the first bit SHALL be valid in the cycle after the load edge and done SHALL assert WIDTH+1 cycles after that edge.
REQ-024 The counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL never wrap within a transfer.
REQ-025 The earliest next load SHALL be accepted in the first IDLE cycle after DONE; the minimum word-to-word period is WIDTH+2 cycles.

Reset
REQ-026 clr_n=0 SHALL immediately, without a clock edge, force state=IDLE, shift register=0 and counter=0, and thus sout=0, sout_valid=0, busy=0, done=0.
REQ-027 A reset asserted during SHIFT or DONE SHALL abort the transfer with no done pulse; after release, the next load SHALL behave as from power-up.
REQ-028 Reset release SHALL take effect at the first rising clk edge after clr_n returns to 1.

Structure
REQ-029 State encodings (IDLE=2'b00, SHIFT=2'b01, DONE=2'b10) SHALL live in the shared serializer_defs package/include, not be hard-coded locally.
REQ-030 The bit counter SHALL be a separate sub-module, bit_counter (clk, clr_n, clear, inc, count), reusable by a future deserializer.
REQ-031 The shift register and FSM SHALL live in register_serializer; there SHALL be no latches or derived clocks.

Verification
REQ-032 Bench SHALL cover: clr_n=0 for 3 cycles with load=1, d=32'hFFFFFFFF -> sout=0, sout_valid=0, busy=0, done=0 throughout; IDLE after release.
REQ-033 Bench SHALL cover: LSB_FIRST=1, load d=32'hA5A50001, en=1 -> serial stream 1,0,0,...,1,0,1,0,0,1,0,1 (bit0..bit31); done high in cycle 33 after the load edge.
REQ-034 Bench SHALL cover: same word with en alternating 1/0 each cycle -> identical 32-bit stream on sout_valid cycles only; done 64 cycles after the load.
REQ-035 Bench SHALL cover: load d=32'h12345678, then at bit 5 load d=32'hFFFFFFFF -> second load ignored; the stream remains 32'h12345678 in full.
REQ-036 Bench SHALL cover: clr_n pulsed low at bit 10 -> outputs zero asynchronously, no done pulse; a following load of 32'h0000000F streams correctly.
REQ-037 Bench SHALL cover: LSB_FIRST=0, d=32'h80000000 -> first sout=1, remaining 31 bits 0; busy falls in the cycle after done.
